// File: rtl/shift_req_arbiter.sv
// shift_req_arbiter: round-robin sharing of a 5-stage pipelined barrel shifter between two requesters,
// with an ID pipeline aligned to the shifter latency and a credit-protected response FIFO.
module shift_req_arbiter #(
    parameter int WIDTH      = 32,
    parameter int AMT_W      = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_data,
    input  logic [2*AMT_W-1:0]   req_amt,
    input  logic [1:0]           req_rot,
    output logic [AMT_W-1:0]     sh_amt_o,
    output logic                 sh_rot_o,
    output logic [WIDTH-1:0]     sh_data_o,
    input  logic [WIDTH-1:0]     sh_result_i,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 rsp_id,
    output logic                 idle
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0]    out_q, out_d, cnt_q, cnt_d;
    logic [PW-1:0]    wr_q, rd_q;
    logic             last_q;
    logic [5:0]       pv_q, pid_q;
    logic [AMT_W-1:0] sh_amt_q;
    logic             sh_rot_q;
    logic [WIDTH-1:0] data1_q, sh_data_q;
    logic [WIDTH:0]   mem [FIFO_DEPTH];
    logic             credit, issue, sel, push, pop, rot_sel;
    logic [WIDTH-1:0] data_sel;
    logic [AMT_W-1:0] amt_sel;

    // outstanding is registered, so a pop only frees credit from the following cycle
    always_comb begin
        credit    = out_q < CW'(FIFO_DEPTH);
        issue     = credit & |req_valid;
        sel       = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        req_ready = issue ? (sel ? 2'b10 : 2'b01) : 2'b00;
        data_sel  = sel ? req_data[WIDTH +: WIDTH] : req_data[0 +: WIDTH];
        amt_sel   = sel ? req_amt[AMT_W +: AMT_W] : req_amt[0 +: AMT_W];
        rot_sel   = sel ? req_rot[1] : req_rot[0];
        push      = pv_q[5];
        rsp_valid = cnt_q != '0;
        pop       = rsp_valid & rsp_ready;
        out_d     = out_q + CW'(issue) - CW'(pop);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        rsp_data  = rsp_valid ? mem[rd_q][WIDTH-1:0] : '0;
        rsp_id    = rsp_valid & mem[rd_q][WIDTH];
        idle      = out_q == '0;
    end

    assign sh_amt_o  = sh_amt_q;
    assign sh_rot_o  = sh_rot_q;
    assign sh_data_o = sh_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            last_q    <= 1'b1;
            pv_q      <= '0;
            pid_q     <= '0;
            sh_amt_q  <= '0;
            sh_rot_q  <= 1'b0;
            data1_q   <= '0;
            sh_data_q <= '0;
        end else begin
            out_q     <= out_d;
            cnt_q     <= cnt_d;
            // data lags amount/rotate by one cycle to match the shifter's internal staging
            sh_amt_q  <= issue ? amt_sel : '0;
            sh_rot_q  <= issue & rot_sel;
            data1_q   <= issue ? data_sel : '0;
            sh_data_q <= data1_q;
            pv_q      <= {pv_q[4:0], issue};
            pid_q     <= {pid_q[4:0], sel};
            if (issue)
                last_q <= sel;
            if (push)
                wr_q <= (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (pop)
                rd_q <= (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_q] <= {pid_q[5], sh_result_i};
    end
endmodule

// File: tb/tb_shift_req_arbiter.sv
// tb_shift_req_arbiter: drives the arbiter with a behavioural shifter model attached and checks
// every cycle against a queue-based reference of issued operations.
module tb_shift_req_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0, req_ready, req_rot = '0;
    logic [63:0] req_data = '0;
    logic [9:0]  req_amt = '0;
    logic [4:0]  sh_amt_o;
    logic        sh_rot_o, rsp_valid, rsp_ready = 1'b0, rsp_id, idle;
    logic [31:0] sh_data_o, sh_result_i, rsp_data;

    int checks = 0;
    int errors = 0;

    shift_req_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt), .req_rot(req_rot),
        .sh_amt_o(sh_amt_o), .sh_rot_o(sh_rot_o), .sh_data_o(sh_data_o), .sh_result_i(sh_result_i),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .idle(idle)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a, input logic r);
        logic [63:0] w;
        w = {d, d} >> a;
        return r ? w[31:0] : d >> a;
    endfunction

    // shifter: amount/rotate in cycle H+1, data in H+2, result in H+6
    logic [4:0]  m_amt;
    logic        m_rot;
    logic [31:0] s1, s2, s3, s4;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_amt <= '0; m_rot <= 1'b0; s1 <= '0; s2 <= '0; s3 <= '0; s4 <= '0;
        end else begin
            m_amt <= sh_amt_o;
            m_rot <= sh_rot_o;
            s1 <= ref_shift(sh_data_o, m_amt, m_rot);
            s2 <= s1;
            s3 <= s2;
            s4 <= s3;
        end
    end
    assign sh_result_i = s4;

    typedef struct { logic [31:0] data; logic id; int rdy; } exp_t;
    exp_t q[$];
    logic m_last = 1'b1;
    int   k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [4:0] a0, input logic [4:0] a1, input logic r0, input logic r1,
                        input logic rr, output logic [1:0] gnt, output logic rv);
        logic [1:0] eg;
        logic       erv;
        exp_t       e;
        @(negedge clk);
        req_valid = v; req_data = {d1, d0}; req_amt = {a1, a0}; req_rot = {r1, r0}; rsp_ready = rr;
        #1;
        eg = (q.size() >= 8 || v == 2'b00) ? 2'b00 : (v == 2'b11) ? (m_last ? 2'b01 : 2'b10) : v;
        erv = q.size() > 0 && q[0].rdy <= k;
        chk("req_ready", {30'd0, req_ready}, {30'd0, eg});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, erv});
        if (erv) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
        end
        chk("idle", {31'd0, idle}, {31'd0, q.size() == 0});
        gnt = req_ready;
        rv = rsp_valid;
        if (erv && rr) void'(q.pop_front());
        if (eg != 2'b00) begin
            e.id = eg[1];
            e.data = eg[1] ? ref_shift(d1, a1, r1) : ref_shift(d0, a0, r0);
            e.rdy = k + 7;
            q.push_back(e);
            m_last = eg[1];
        end
        k++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0; rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_last = 1'b1;
    endtask

    task automatic idle_step(input logic rr, output logic rv);
        logic [1:0] g;
        step(2'b00, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, rr, g, rv);
    endtask

    task automatic drain(input int bound);
        logic rv;
        int   n;
        n = 0;
        while (q.size() > 0 && n < bound) begin
            idle_step(1'b1, rv);
            n++;
        end
        chk("drain_done", {31'd0, q.size() == 0}, 32'd1);
    endtask

    typedef struct { logic rid; logic [31:0] d; logic [4:0] a; logic r; logic [31:0] exp; } vec_t;
    vec_t tbl[7];

    initial begin
        logic [1:0] g;
        logic       rv;
        int         lat, hs, pops;
        tbl[0] = '{1'b0, 32'h80000001, 5'd1,  1'b1, 32'hC0000000};
        tbl[1] = '{1'b1, 32'hF0000000, 5'd4,  1'b0, 32'h0F000000};
        tbl[2] = '{1'b0, 32'h80000000, 5'd31, 1'b0, 32'h00000001};
        tbl[3] = '{1'b1, 32'h12345678, 5'd0,  1'b0, 32'h12345678};
        tbl[4] = '{1'b0, 32'h12345678, 5'd0,  1'b1, 32'h12345678};
        tbl[5] = '{1'b1, 32'h00000001, 5'd31, 1'b1, 32'h00000002};
        tbl[6] = '{1'b0, 32'h0000000F, 5'd4,  1'b1, 32'hF0000000};

        do_reset();
        #1;
        chk("rst_idle", {31'd0, idle}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_sh_data", sh_data_o, 32'd0);

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].rid ? 2'b10 : 2'b01, tbl[i].d, tbl[i].d, tbl[i].a, tbl[i].a,
                 tbl[i].r, tbl[i].r, 1'b1, g, rv);
            chk("tbl_grant", {30'd0, g}, tbl[i].rid ? 32'd2 : 32'd1);
            lat = 0;
            rv = 1'b0;
            while (!rv && lat < 12) begin
                lat++;
                idle_step(1'b1, rv);
            end
            chk("tbl_latency", lat, 7);
            chk("tbl_data", rsp_data, tbl[i].exp);
            chk("tbl_id", {31'd0, rsp_id}, {31'd0, tbl[i].rid});
            idle_step(1'b1, rv);
            chk("tbl_idle", {31'd0, idle}, 32'd1);
        end

        // contention: grants alternate from requester 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(2'b11, $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom), 1'($urandom), 1'b1, g, rv);
            chk("contend_grant", {30'd0, g}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        drain(20);

        // back-pressure: exactly FIFO_DEPTH accepts, then drain in order
        do_reset();
        hs = 0;
        for (int i = 0; i < 14; i++) begin
            step(2'b01, $urandom, 32'd0, 5'($urandom_range(0, 31)), 5'd0, 1'($urandom), 1'b0, 1'b0, g, rv);
            if (g != 2'b00) hs++;
        end
        chk("bp_handshakes", hs, 8);
        chk("bp_ready_low", {30'd0, req_ready}, 32'd0);
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            idle_step(1'b1, rv);
            if (rv) pops++;
        end
        chk("bp_pops", pops, 8);
        step(2'b01, 32'hA5A5A5A5, 32'd0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, g, rv);
        chk("bp_resume", {30'd0, g}, 32'd1);
        drain(12);

        // full credit: 7 buffered + 1 in flight, credit returns the cycle after a pop
        do_reset();
        for (int i = 0; i < 7; i++)
            step(2'b01, $urandom, 32'd0, 5'($urandom_range(0, 31)), 5'd0, 1'b0, 1'b0, 1'b0, g, rv);
        for (int i = 0; i < 7; i++) idle_step(1'b0, rv);
        step(2'b10, 32'd0, 32'hDEADBEEF, 5'd0, 5'd12, 1'b0, 1'b1, 1'b0, g, rv);
        chk("fc_last_credit", {30'd0, g}, 32'd2);
        step(2'b10, 32'd0, 32'h1, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, g, rv);
        chk("fc_no_credit", {30'd0, g}, 32'd0);
        step(2'b10, 32'd0, 32'h2, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, g, rv);
        chk("fc_pop_same_cycle", {30'd0, g}, 32'd0);
        step(2'b10, 32'd0, 32'h3, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, g, rv);
        chk("fc_credit_next", {30'd0, g}, 32'd2);
        for (int i = 0; i < 40 && q.size() > 0; i++) idle_step(1'(i % 2), rv);
        chk("fc_drained", {31'd0, q.size() == 0}, 32'd1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++)
            step(2'($urandom), $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, g, rv);
        drain(40);

        // reset mid-flight
        do_reset();
        for (int i = 0; i < 3; i++)
            step(2'b01, $urandom, 32'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, g, rv);
        @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        #1;
        chk("mid_rst_idle", {31'd0, idle}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_sh_amt", {27'd0, sh_amt_o}, 32'd0);
        chk("mid_rst_sh_data", sh_data_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_last = 1'b1;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            idle_step(1'b1, rv);
            if (rv) pops++;
        end
        chk("mid_rst_no_rsp", pops, 0);
        step(2'b11, 32'h1, 32'h2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, g, rv);
        chk("mid_rst_first_grant", {30'd0, g}, 32'd1);
        drain(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
